// File: rtl/bus_arbiter_if.sv
// Bus ownership handshake between the DMA controller / CPU memory stage
// and the M2 bus arbiter, plus the arbiter's status readback.
interface bus_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             BR;
    logic             M2busy;
    logic             BG;
    logic             cpu_bus_stall;
    logic [15:0]      grant_cycles;
    logic [CNT_W-1:0] grant_count;
    logic             bus_timeout;

    modport master (
        output BR,
        output M2busy,
        input  BG,
        input  cpu_bus_stall,
        input  grant_cycles,
        input  grant_count,
        input  bus_timeout
    );

    modport slave (
        input  BR,
        input  M2busy,
        output BG,
        output cpu_bus_stall,
        output grant_cycles,
        output grant_count,
        output bus_timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// M2 bus arbiter: CPU owns the bus by default, DMA takes it via BR/BG
// after in-flight CPU traffic drains; one-cycle turnaround on release.
module bus_arbiter #(
    parameter int CPU_HOLD  = 4,
    parameter int MAX_GRANT = 64,
    parameter int CNT_W     = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    bus_arbiter_if.slave bus
);
    localparam int WORD_SIZE = 16;
    localparam int HOLD_W    = $clog2(CPU_HOLD + 2);

    typedef enum logic [1:0] {
        CPU_OWN,
        DRAIN,
        DMA_OWN,
        TURNAROUND
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [WORD_SIZE-1:0]  gcyc_q, gcyc_d;
    logic [CNT_W-1:0]      gcnt_q, gcnt_d;
    logic                  tout_q, tout_d;

    // Next-state and counter updates for the ownership handshake
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gcyc_d  = gcyc_q;
        gcnt_d  = gcnt_q;
        tout_d  = tout_q;
        unique case (state_q)
            CPU_OWN: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (bus.BR) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.BR) begin
                    state_d = CPU_OWN;
                end else if (!bus.M2busy) begin
                    state_d = DMA_OWN;
                    gcyc_d  = '0;
                end
            end
            DMA_OWN: begin
                if (gcyc_q != {WORD_SIZE{1'b1}}) begin
                    gcyc_d = gcyc_q + WORD_SIZE'(1);
                end
                if (bus.BR && (gcyc_q == WORD_SIZE'(MAX_GRANT - 1))) begin
                    tout_d = 1'b1;
                end
                if (!bus.BR) begin
                    state_d = TURNAROUND;
                end
            end
            TURNAROUND: begin
                state_d = CPU_OWN;
                hold_d  = HOLD_W'(CPU_HOLD);
                gcnt_d  = gcnt_q + CNT_W'(1);
            end
            default: state_d = CPU_OWN;
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CPU_OWN;
            hold_q  <= '0;
            gcyc_q  <= '0;
            gcnt_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gcyc_q  <= gcyc_d;
            gcnt_q  <= gcnt_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.BG            = (state_q == DMA_OWN);
    assign bus.cpu_bus_stall = (state_q != CPU_OWN);
    assign bus.grant_cycles  = gcyc_q;
    assign bus.grant_count   = gcnt_q;
    assign bus.bus_timeout   = tout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random
// BR/M2busy/Reset traffic against a behavioural ownership model.
module tb_bus_arbiter;
    localparam int CPU_HOLD  = 4;
    localparam int MAX_GRANT = 64;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic        bg;
        logic        stall;
        logic [15:0] gcyc;
        logic [7:0]  gcnt;
        logic        tout;
    } exp_t;

    logic Clk;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    bus_arbiter_if #(.CNT_W(CNT_W)) bus_if ();

    bus_arbiter #(
        .CPU_HOLD (CPU_HOLD),
        .MAX_GRANT(MAX_GRANT),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus_if)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Behavioural model: who holds the bus and what is pending.
    bit dma_has_bus = 0;
    bit waiting     = 0;
    bit returning   = 0;
    int hold        = 0;
    int gcyc        = 0;
    int gcount      = 0;
    bit tout        = 0;

    task automatic model_edge(input bit br, input bit busy, input bit rst);
        if (rst) begin
            dma_has_bus = 0; waiting = 0; returning = 0;
            hold = 0; gcyc = 0; gcount = 0; tout = 0;
        end else if (returning) begin
            returning = 0;
            hold      = CPU_HOLD;
            gcount    = (gcount + 1) % (1 << CNT_W);
        end else if (dma_has_bus) begin
            if (br && gcyc == MAX_GRANT - 1) tout = 1;
            if (gcyc < 65535) gcyc = gcyc + 1;
            if (!br) begin
                dma_has_bus = 0;
                returning   = 1;
            end
        end else if (waiting) begin
            if (!br) begin
                waiting = 0;
            end else if (!busy) begin
                waiting     = 0;
                dma_has_bus = 1;
                gcyc        = 0;
            end
        end else begin
            if (hold > 0) hold = hold - 1;
            else if (br) waiting = 1;
        end
    endtask

    task automatic cyc(input bit br, input bit busy, input bit rst);
        exp_t e;
        bus_if.BR     = br;
        bus_if.M2busy = busy;
        Reset         = rst;
        model_edge(br, busy, rst);
        e.bg    = dma_has_bus;
        e.stall = dma_has_bus | waiting | returning;
        e.gcyc  = 16'(gcyc);
        e.gcnt  = 8'(gcount);
        e.tout  = tout;
        sb_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs after each edge with the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("BG", 32'(bus_if.BG), 32'(e.bg));
                chk("stall", 32'(bus_if.cpu_bus_stall), 32'(e.stall));
                chk("grant_cycles", 32'(bus_if.grant_cycles), 32'(e.gcyc));
                chk("grant_count", 32'(bus_if.grant_count), 32'(e.gcnt));
                chk("bus_timeout", 32'(bus_if.bus_timeout), 32'(e.tout));
            end
        end
    end

    initial begin
        bit br;
        bit busy;
        bit rst;
        // reset and idle
        repeat (2) cyc(0, 0, 1);
        repeat (3) cyc(0, 0, 0);
        // 12-cycle grant then release
        repeat (13) cyc(1, 0, 0);
        cyc(0, 0, 0);
        // immediate re-request sits out the CPU hold window
        repeat (10) cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        repeat (5) cyc(0, 0, 0);
        // request while M2 busy for 3 cycles
        cyc(1, 1, 0);
        repeat (3) cyc(1, 1, 0);
        repeat (4) cyc(1, 0, 0);
        repeat (8) cyc(0, 0, 0);
        // one-cycle BR pulse during DRAIN with M2 busy
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        repeat (4) cyc(0, 0, 0);
        // withdrawal wins over drain completion
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        repeat (3) cyc(0, 0, 0);
        // release on the very edge that would time out
        repeat (65) cyc(1, 0, 0);
        cyc(0, 0, 0);
        repeat (8) cyc(0, 0, 0);
        // overlong grant: timeout sticks past release
        repeat (72) cyc(1, 0, 0);
        repeat (10) cyc(0, 0, 0);
        repeat (8) cyc(1, 0, 0);
        cyc(0, 0, 0);
        repeat (6) cyc(0, 0, 0);
        // reset mid-grant
        repeat (6) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (3) cyc(0, 0, 0);
        // random traffic
        br = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0) br = ~br;
            busy = ($urandom_range(2) == 0);
            rst  = ($urandom_range(299) == 0);
            cyc(br, busy, rst);
        end
        repeat (2) @(negedge Clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
